// File: rtl/tx_framer_mux.sv
// rtl/tx_framer_mux.sv - transmit framer: STP/SDP + payload + PAD + END/EDB, IDL fill, periodic COM+SKP (optional feature macro TX_FRAMER_NULLIFY_EN adds pkt_abort / EDB)
module tx_framer_mux #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       pkt_valid,
  input  logic [7:0] pkt_data,
  input  logic       pkt_last,
  input  logic       pkt_type,
`ifdef TX_FRAMER_NULLIFY_EN
  input  logic       pkt_abort,
`endif
  output logic       pkt_ready,
  output logic [7:0] data_out,
  output logic       k_out
);

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_IDL = 8'h7C;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SKP  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_PAD  = 3'd3;
  localparam logic [2:0] S_EOF  = 3'd4;

  localparam logic [2:0]  SKP_LAST = 3'(SKP_LEN - 1);
  localparam logic [15:0] SKP_WRAP = 16'(SKP_INTERVAL - 1);

  logic [2:0]  state, nxt_state;
  logic [1:0]  pos, nxt_pos, pos_inc;
  logic [2:0]  skp_idx, nxt_idx;
  logic [15:0] skp_cnt;
  logic        skp_pending;
  logic        skp_done;
  logic        edb, nxt_edb;
  logic [7:0]  nxt_data;
  logic        nxt_k;
  logic        abort;

`ifdef TX_FRAMER_NULLIFY_EN
  assign abort = pkt_abort;
`else
  assign abort = 1'b0;
`endif

  assign pkt_ready = (state == S_DATA);
  assign pos_inc   = pos + 2'd1;

  // Next symbol and next state; the chosen symbol is registered onto data_out/k_out
  always_comb begin
    nxt_state = state;
    nxt_pos   = pos;
    nxt_idx   = skp_idx;
    nxt_edb   = edb;
    nxt_data  = SYM_IDL;
    nxt_k     = 1'b1;
    skp_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (skp_pending) begin
          nxt_data  = SYM_COM;
          nxt_state = S_SKP;
        end else if (pkt_valid) begin
          nxt_data  = pkt_type ? SYM_SDP : SYM_STP;
          nxt_pos   = 2'd1;
          nxt_edb   = 1'b0;
          nxt_state = S_DATA;
        end
      end
      S_SKP: begin
        nxt_data = SYM_SKP;
        if (skp_idx == SKP_LAST) begin
          nxt_idx   = 3'd0;
          skp_done  = 1'b1;
          nxt_state = S_IDLE;
        end else begin
          nxt_idx = skp_idx + 3'd1;
        end
      end
      S_DATA: begin
        nxt_pos = pos_inc;
        if (pkt_valid) begin
          nxt_data = pkt_data;
          nxt_k    = 1'b0;
          if (pkt_last || abort) begin
            nxt_edb   = abort;
            nxt_state = (pos_inc == 2'd3) ? S_EOF : S_PAD;
          end
        end else begin
          // Underrun: fill with PAD, which still advances frame alignment
          nxt_data = SYM_PAD;
          if (abort) begin
            nxt_edb   = 1'b1;
            nxt_state = (pos_inc == 2'd3) ? S_EOF : S_PAD;
          end
        end
      end
      S_PAD: begin
        nxt_data = SYM_PAD;
        nxt_pos  = pos_inc;
        if (pos_inc == 2'd3) nxt_state = S_EOF;
      end
      S_EOF: begin
        nxt_data  = edb ? SYM_EDB : SYM_END;
        nxt_pos   = 2'd0;
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_pos   = 2'd0;
      end
    endcase
  end

  // Framing state and registered symbol output
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state    <= S_IDLE;
      pos      <= 2'd0;
      skp_idx  <= 3'd0;
      edb      <= 1'b0;
      data_out <= SYM_IDL;
      k_out    <= 1'b1;
    end else begin
      state    <= nxt_state;
      pos      <= nxt_pos;
      skp_idx  <= nxt_idx;
      edb      <= nxt_edb;
      data_out <= nxt_data;
      k_out    <= nxt_k;
    end
  end

  // Free-running SKP interval counter; a wrap raises the single pending request
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      skp_cnt     <= 16'd0;
      skp_pending <= 1'b0;
    end else if (skp_cnt == SKP_WRAP) begin
      skp_cnt     <= 16'd0;
      skp_pending <= 1'b1;
    end else begin
      skp_cnt <= skp_cnt + 16'd1;
      if (skp_done) skp_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_framer_mux.sv
// tb/tb_tx_framer_mux.sv - self-checking bench for tx_framer_mux
module tb_tx_framer_mux;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       a_valid = 1'b0, a_last = 1'b0, a_type = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_ready, a_k;
  logic [7:0] a_dout;
  logic       s_valid = 1'b0, s_last = 1'b0, s_type = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, s_k;
  logic [7:0] s_dout;
`ifdef TX_FRAMER_NULLIFY_EN
  logic       a_abort = 1'b0;
  logic       s_abort = 1'b0;
`endif

  always #5 clk = ~clk;

  tx_framer_mux dut_a (
    .clk(clk), .reset_L(reset_L), .pkt_valid(a_valid), .pkt_data(a_data),
    .pkt_last(a_last), .pkt_type(a_type),
`ifdef TX_FRAMER_NULLIFY_EN
    .pkt_abort(a_abort),
`endif
    .pkt_ready(a_ready), .data_out(a_dout), .k_out(a_k)
  );

  tx_framer_mux #(.SKP_INTERVAL(32), .SKP_LEN(3)) dut_s (
    .clk(clk), .reset_L(reset_L), .pkt_valid(s_valid), .pkt_data(s_data),
    .pkt_last(s_last), .pkt_type(s_type),
`ifdef TX_FRAMER_NULLIFY_EN
    .pkt_abort(s_abort),
`endif
    .pkt_ready(s_ready), .data_out(s_dout), .k_out(s_k)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       t;
    logic [7:0] ed;
    logic       ek;
    logic       er;
  } vec_t;

  vec_t vt[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %02h want %02h", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic v, input logic [7:0] d, input logic l,
                              input logic t, input logic [7:0] ed, input logic ek, input logic er);
    vec_t x;
    x.rst = rst; x.v = v; x.d = d; x.l = l; x.t = t; x.ed = ed; x.ek = ek; x.er = er;
    vt.push_back(x);
  endfunction

  logic [7:0] exp_sym [21];
  logic       exp_k   [21];
  logic [7:0] cap_sym [21];
  logic       cap_k   [21];

  initial begin
    // reset held with traffic offered, then one idle post-reset cycle
    add(0, 1, 8'hAA, 0, 0, 8'h7C, 1, 0);
    add(0, 1, 8'hAA, 0, 0, 8'h7C, 1, 0);
    add(0, 1, 8'hAA, 0, 0, 8'h7C, 1, 0);
    add(1, 0, 8'h00, 0, 0, 8'h7C, 1, 0);
    // TLP L=2
    add(1, 1, 8'hAA, 0, 0, 8'hFB, 1, 1);
    add(1, 1, 8'hAA, 0, 0, 8'hAA, 0, 1);
    add(1, 1, 8'hBB, 1, 0, 8'hBB, 0, 0);
    add(1, 0, 8'h00, 0, 0, 8'hFD, 1, 0);
    add(1, 0, 8'h00, 0, 0, 8'h7C, 1, 0);
    // DLLP L=5
    add(1, 1, 8'h01, 0, 1, 8'h5C, 1, 1);
    add(1, 1, 8'h01, 0, 1, 8'h01, 0, 1);
    add(1, 1, 8'h02, 0, 1, 8'h02, 0, 1);
    add(1, 1, 8'h03, 0, 1, 8'h03, 0, 1);
    add(1, 1, 8'h04, 0, 1, 8'h04, 0, 1);
    add(1, 1, 8'h05, 1, 1, 8'h05, 0, 0);
    add(1, 0, 8'h00, 0, 0, 8'hF7, 1, 0);
    add(1, 0, 8'h00, 0, 0, 8'hFD, 1, 0);
    // L=1 with two underrun cycles
    add(1, 1, 8'h11, 0, 0, 8'hFB, 1, 1);
    add(1, 0, 8'h11, 0, 0, 8'hF7, 1, 1);
    add(1, 0, 8'h11, 0, 0, 8'hF7, 1, 1);
    add(1, 1, 8'h11, 1, 0, 8'h11, 0, 0);
    add(1, 0, 8'h00, 0, 0, 8'hF7, 1, 0);
    add(1, 0, 8'h00, 0, 0, 8'hF7, 1, 0);
    add(1, 0, 8'h00, 0, 0, 8'hF7, 1, 0);
    add(1, 0, 8'h00, 0, 0, 8'hFD, 1, 0);
    add(1, 0, 8'h00, 0, 0, 8'h7C, 1, 0);
    // back-to-back: valid held across END, next SDP follows immediately
    add(1, 1, 8'hCC, 0, 0, 8'hFB, 1, 1);
    add(1, 1, 8'hCC, 0, 0, 8'hCC, 0, 1);
    add(1, 1, 8'hDD, 1, 0, 8'hDD, 0, 0);
    add(1, 1, 8'h33, 0, 1, 8'hFD, 1, 0);
    add(1, 1, 8'h33, 0, 1, 8'h5C, 1, 1);
    add(1, 1, 8'h33, 1, 1, 8'h33, 0, 0);
    add(1, 0, 8'h00, 0, 0, 8'hF7, 1, 0);
    add(1, 0, 8'h00, 0, 0, 8'hFD, 1, 0);
    add(1, 0, 8'h00, 0, 0, 8'h7C, 1, 0);
    // reset mid-packet abandons the frame with no END
    add(1, 1, 8'h77, 0, 0, 8'hFB, 1, 1);
    add(1, 1, 8'h77, 0, 0, 8'h77, 0, 1);
    add(0, 1, 8'h78, 0, 0, 8'h7C, 1, 0);
    add(1, 0, 8'h00, 0, 0, 8'h7C, 1, 0);
    add(1, 0, 8'h00, 0, 0, 8'h7C, 1, 0);

    for (int i = 0; i < vt.size(); i++) begin
      reset_L = vt[i].rst;
      a_valid = vt[i].v;
      a_data  = vt[i].d;
      a_last  = vt[i].l;
      a_type  = vt[i].t;
      @(posedge clk);
      #1;
      chk("vec_data", i, a_dout, vt[i].ed);
      chk("vec_k", i, {7'd0, a_k}, {7'd0, vt[i].ek});
      chk("vec_ready", i, {7'd0, a_ready}, {7'd0, vt[i].er});
    end

    // SKP cadence on an idle link (interval 32, three SKPs)
    a_valid = 1'b0;
    reset_L = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    for (int k = 1; k < 120; k++) begin
      logic [7:0] e;
      @(posedge clk);
      #1;
      e = 8'h7C;
      if (k >= 33 && (k % 32) == 1) e = 8'hBC;
      if (k >= 34 && (k % 32) >= 2 && (k % 32) <= 4) e = 8'h1C;
      chk("skp_idle", k, s_dout, e);
      if (s_k !== 1'b1) chk("skp_idle_k", k, {7'd0, s_k}, 8'd1);
    end

    // SKP request raised mid-frame is served right after END
    exp_sym[0] = 8'hFB; exp_k[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_sym[1 + i] = 8'hA0 + 8'(i);
      exp_k[1 + i]   = 1'b0;
    end
    exp_sym[13] = 8'hF7; exp_sym[14] = 8'hF7; exp_sym[15] = 8'hFD; exp_sym[16] = 8'hBC;
    exp_sym[17] = 8'h1C; exp_sym[18] = 8'h1C; exp_sym[19] = 8'h1C; exp_sym[20] = 8'hFB;
    for (int i = 13; i < 21; i++) exp_k[i] = 1'b1;
    begin
      int idx;
      logic acc;
      idx = 0;
      for (int i = 0; i < 21; i++) begin
        s_valid = 1'b1;
        s_type  = 1'b0;
        s_data  = (idx < 12) ? 8'hA0 + 8'(idx) : 8'h55;
        s_last  = (idx == 11);
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        cap_sym[i] = s_dout;
        cap_k[i]   = s_k;
        if (acc) idx++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
    for (int i = 0; i < 21; i++) begin
      chk("skp_frame_data", i, cap_sym[i], exp_sym[i]);
      chk("skp_frame_k", i, {7'd0, cap_k[i]}, {7'd0, exp_k[i]});
    end

`ifdef TX_FRAMER_NULLIFY_EN
    // nullified frame: abort on byte 3, pad to lane 3, terminate with EDB
    begin
      logic [7:0] ab_d  [9] = '{8'hB1, 8'hB1, 8'hB2, 8'hB3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      logic       ab_v  [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
      logic       ab_a  [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
      logic [7:0] ab_e  [9] = '{8'hFB, 8'hB1, 8'hB2, 8'hB3, 8'hF7, 8'hF7, 8'hF7, 8'hFE, 8'h7C};
      for (int i = 0; i < 9; i++) begin
        a_valid = ab_v[i];
        a_data  = ab_d[i];
        a_abort = ab_a[i];
        a_last  = 1'b0;
        a_type  = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_data", i, a_dout, ab_e[i]);
      end
      a_abort = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_framer_mux.md
Name: tx_framer_mux

Overview:
- Transmit-side symbol source directly upstream of the lane striping stage; its 8-bit output is the striping block's byte input.
- Accepts packet bytes from the link layer over a valid/ready interface and wraps each packet as STP/SDP, payload, PAD, END.
- Pads every packet so the frame length is a multiple of 4, which lands END on lane 3.
- Emits IDL when there is no traffic, and inserts periodic COM+SKP ordered sets between packets.

Parameters:
- SKP_INTERVAL, 1180: clock cycles between SKP ordered-set requests (16-bit counter).
- SKP_LEN, 3: number of SKP symbols following COM in each ordered set (1..7).

Ports:
- clk  in  1  rising-edge clock.
- reset_L  in  1  synchronous active-low reset.
- pkt_valid  in  1  upstream byte valid.
- pkt_data  in  8  upstream payload byte.
- pkt_last  in  1  marks the final payload byte of the packet.
- pkt_type  in  1  sampled at packet start: 0 = TLP (STP), 1 = DLLP (SDP).
- pkt_ready  out  1  framer accepts a byte this cycle. Equals (state==DATA); combinational from the state register.
- data_out  out  8  registered symbol to striping.
- k_out  out  1  registered; 1 = control symbol, 0 = payload byte.

Behaviour:
- Symbol codes: COM BC, PAD F7, SKP 1C, STP FB, SDP 5C, END FD, EDB FE, IDL 7C. k_out=1 for all of these; k_out=0 for payload bytes.
- Reset (reset_L=0 at an edge):
  - state=IDLE, data_out=IDL, k_out=1, pkt_ready=0.
  - pos=0, skp_cnt=0, skp_pending=0, skp_idx=0.
  - Reset mid-packet abandons the frame immediately; no END is emitted.
- One symbol is emitted per clock. data_out/k_out reflect the decision made in the previous cycle.
- pos[1:0] counts the frame position modulo 4. The STP/SDP symbol is position 0.
- States:
  - IDLE:
    - If skp_pending: emit COM, go to SKP.
    - Else if pkt_valid: emit STP (pkt_type=0) or SDP (pkt_type=1), set pos=1, go to DATA.
    - Else: emit IDL.
    - SKP has priority over a packet start when both are present.
  - SKP:
    - Emit SKP and increment skp_idx.
    - After SKP_LEN SKPs: clear skp_pending and skp_idx, go to IDLE.
  - DATA (pkt_ready=1):
    - On pkt_valid: emit pkt_data with k_out=0, pos+=1.
    - If pkt_last: go to EOF when the new pos==3, else go to PAD.
    - Underrun (pkt_valid=0 in DATA): emit PAD with k_out=1, pos+=1, stay in DATA. The PAD counts toward alignment.
  - PAD: emit PAD, pos+=1. When the new pos==3, go to EOF.
  - EOF: emit END (pos is 3), pos=0, go to IDLE.
- Pad count for L payload bytes with no underrun: P=(2-L) mod 4. Frame length = 1+L+P+1 ≡ 0 mod 4.
- Latency: the byte accepted at edge N appears on data_out after edge N; the first payload byte is accepted the cycle after STP appears.
- Back-to-back packets: pkt_valid held high after END produces STP on the very next symbol, with no IDL in between (unless a SKP is pending).
- SKP counter:
  - skp_cnt increments every cycle in every state.
  - At SKP_INTERVAL-1 it wraps to 0 and sets skp_pending.
  - A wrap while skp_pending is already set is absorbed; at most one ordered set is ever pending.
  - Ordered sets are never inserted inside a frame; a request raised mid-packet is served in the IDLE cycle after END.
- Zero-length packets are not legal: pkt_last must accompany at least one payload byte.

Optional Feature:
- Macro: TX_FRAMER_NULLIFY_EN.
- Defined: adds input port pkt_abort (1 bit), sampled with accepted bytes.
  - An accepted byte with pkt_abort=1 is treated as last.
  - Padding proceeds as normal, and the frame terminates with EDB instead of END.
  - pkt_abort on an underrun cycle also terminates the frame: pad to pos 3, then EDB.
- Undefined: the port does not exist and frames always terminate with END.

Test Plan:
- Reset: hold reset_L=0 for 3 cycles with pkt_valid=1 -> data_out=7C, k_out=1, pkt_ready=0 throughout, and for the first post-reset cycle.
- TLP with L=2 (AA, BB; pkt_type=0) -> FB, AA, BB, FD with k=1,0,0,1; then 7C.
- DLLP with L=5 (01..05) -> 5C, 01..05, F7, FD (8 symbols); END is at position 3.
- L=1 with a 2-cycle underrun after STP -> FB, F7, F7, 11, F7, F7, F7, FD (F7 ×2 underrun, then the byte, then 3 alignment PADs); total 8 symbols.
- SKP_INTERVAL=32, SKP_LEN=3, idle link -> every 32 cycles BC, 1C, 1C, 1C, with IDL otherwise.
  - Skp request during a 12-byte TLP -> frame intact; BC, 1C, 1C, 1C immediately follow END, then the next STP.
- TX_FRAMER_NULLIFY_EN: L=3 with pkt_abort on byte 3 -> FB, b1, b2, b3, F7, F7, F7, FE.
